// File: rtl/spi_auth_sequencer_if.sv
// Bundles the request side and the SPI-master side of the authentication sequencer.
// The slave modport is the sequencer's view. The master modport is its environment.
interface spi_auth_sequencer_if #(
    parameter int KEY_LENGTH = 32
);
    logic                  auth_req;
    logic [KEY_LENGTH-1:0] challenge;
    logic [KEY_LENGTH-1:0] expected_resp;
    logic                  spi_start;
    logic [KEY_LENGTH-1:0] spi_data_to_send;
    logic [KEY_LENGTH-1:0] spi_data_received;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  fail;
    logic [3:0]            attempts;
    logic [KEY_LENGTH-1:0] response;

    modport slave (
        input  auth_req, challenge, expected_resp, spi_data_received,
        output spi_start, spi_data_to_send, busy, done, pass, fail, attempts, response
    );

    modport master (
        output auth_req, challenge, expected_resp, spi_data_received,
        input  spi_start, spi_data_to_send, busy, done, pass, fail, attempts, response
    );
endinterface

// File: rtl/spi_auth_sequencer.sv
// Runs one challenge-response exchange over the 3-wire SPI master, retrying a bounded number of times.
// The master has no done output, so every transfer is timed here by a fixed cycle budget.
module spi_auth_sequencer #(
    parameter int KEY_LENGTH                  = 32,
    parameter int SCLK_PERIOD_AS_CLK_MULTIPLE = 10,
    parameter int XFER_WAIT                   = (KEY_LENGTH + 2) * SCLK_PERIOD_AS_CLK_MULTIPLE + 8,
    parameter int GAP_CYCLES                  = 16,
    parameter int MAX_ATTEMPTS                = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_auth_sequencer_if.slave   bus
);

    localparam int CNT_MAX = (XFER_WAIT > GAP_CYCLES) ? XFER_WAIT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] XFER_WAIT_C  = CNT_W'(XFER_WAIT);
    localparam logic [CNT_W-1:0] GAP_C        = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] START_LEN_C  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       MAX_ATT_C    = 4'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_GAP
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  start_q, start_d;
    logic [KEY_LENGTH-1:0] data_q, data_d;
    logic [KEY_LENGTH-1:0] exp_q, exp_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic [3:0]            att_q, att_d;
    logic [KEY_LENGTH-1:0] resp_q, resp_d;

    // NOTE: sequential state uses <= so every flop samples the pre-edge values together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            att_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            data_q  <= data_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            att_q   <= att_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        data_d  = data_q;
        exp_d   = exp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        att_d   = att_q;
        resp_d  = resp_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.auth_req) begin
                    data_d  = bus.challenge;
                    exp_d   = bus.expected_resp;
                    att_d   = 4'd1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = S_START;
                end
            end
            S_START: begin
                // The master's start synchroniser needs two samples of the high level.
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == START_LEN_C) begin
                    start_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == XFER_WAIT_C) begin
                    resp_d  = bus.spi_data_received;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_CHECK: begin
                if (resp_q == exp_q) begin
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (att_q < MAX_ATT_C) begin
                    att_d   = att_q + 4'd1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_C) begin
                    start_d = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.spi_start        = start_q;
    assign bus.spi_data_to_send = data_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.fail             = fail_q;
    assign bus.attempts         = att_q;
    assign bus.response         = resp_q;

endmodule

// File: tb/tb_spi_auth_sequencer.sv
// Bench for spi_auth_sequencer: a loopback slave answers each start pulse with a planned word.
// Outcomes are compared against arithmetic predictions derived from the exchange rules.
module tb_spi_auth_sequencer;

    localparam int KEY_LENGTH   = 32;
    localparam int SCLK_MULT    = 10;
    localparam int XFER_WAIT    = (KEY_LENGTH + 2) * SCLK_MULT + 8;
    localparam int GAP_CYCLES   = 16;
    localparam int MAX_ATTEMPTS = 3;
    localparam int RETRY_PERIOD = GAP_CYCLES + XFER_WAIT + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_auth_sequencer_if #(.KEY_LENGTH(KEY_LENGTH)) bus ();

    spi_auth_sequencer #(
        .KEY_LENGTH                  (KEY_LENGTH),
        .SCLK_PERIOD_AS_CLK_MULTIPLE (SCLK_MULT),
        .GAP_CYCLES                  (GAP_CYCLES),
        .MAX_ATTEMPTS                (MAX_ATTEMPTS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Slave / monitor state: sampled 1 time unit after every rising edge.
    int              cyc          = 0;
    int              slave_pulses = 0;
    int              slave_base   = 0;
    int              slave_n_wrong = 0;
    logic [31:0]     slave_expected = '0;
    logic [31:0]     slave_mask   = 32'h1;
    int              start_high   = 0;
    int              done_count   = 0;
    int              both_count   = 0;
    int              rise_q[$];
    logic            start_prev   = 1'b0;

    initial bus.spi_data_received = '0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.spi_start && !start_prev) begin
            slave_pulses++;
            rise_q.push_back(cyc);
            bus.spi_data_received = ((slave_pulses - slave_base) <= slave_n_wrong)
                                    ? (slave_expected ^ slave_mask) : slave_expected;
        end
        if (bus.spi_start) start_high++;
        if (bus.done) done_count++;
        if (bus.pass && bus.fail) both_count++;
        start_prev = bus.spi_start;
    end

    task automatic configure_slave(input logic [31:0] exp_w, input int n_wrong);
        slave_expected = exp_w;
        slave_n_wrong  = n_wrong;
        slave_base     = slave_pulses;
        slave_mask     = $urandom | 32'h1;
    endtask

    // Outcome predicted from the retry rules alone.
    function automatic void model(input int n_wrong, output bit p, output int att, output int done_t);
        p      = (n_wrong < MAX_ATTEMPTS);
        att    = p ? n_wrong + 1 : MAX_ATTEMPTS;
        done_t = XFER_WAIT + 1 + (att - 1) * RETRY_PERIOD;
    endfunction

    typedef struct {
        logic [31:0] chal;
        logic [31:0] resp;
        int          n_wrong;
        bit          disturb;
        bit          exp_pass;
        int          exp_att;
        int          exp_done;
    } vec_t;

    task automatic run_exchange(input logic [31:0] chal, input logic [31:0] exp_w, input int n_wrong,
                                input bit disturb, input bit exp_pass, input int exp_att,
                                input int exp_done);
        int t;
        int p0, h0, d0, b0, r0;
        logic [31:0] exp_resp;
        configure_slave(exp_w, n_wrong);
        p0 = slave_pulses; h0 = start_high; d0 = done_count; b0 = both_count; r0 = rise_q.size();
        @(negedge clk);
        bus.auth_req = 1'b1; bus.challenge = chal; bus.expected_resp = exp_w;
        @(negedge clk);
        bus.auth_req = 1'b0; bus.challenge = $urandom; bus.expected_resp = $urandom;
        check("accept_start", bus.spi_start, 1'b1);
        check("accept_busy", bus.busy, 1'b1);
        check("accept_attempts", bus.attempts, 4'd1);
        check("accept_pass_fail", {bus.pass, bus.fail}, 2'b00);
        check("accept_data", bus.spi_data_to_send, chal);
        t = 0;
        while (bus.done !== 1'b1 && t < 6000) begin
            if (disturb && t == 100) begin
                bus.auth_req = 1'b1; bus.challenge = '0; bus.expected_resp = '0;
            end
            if (disturb && t == 101) bus.auth_req = 1'b0;
            @(negedge clk);
            t++;
        end
        exp_resp = exp_pass ? exp_w : (exp_w ^ slave_mask);
        check("done_time", t, exp_done);
        check("done_pass", bus.pass, exp_pass);
        check("done_fail", bus.fail, !exp_pass);
        check("done_attempts", bus.attempts, 4'(exp_att));
        check("done_response", bus.response, exp_resp);
        check("done_data_held", bus.spi_data_to_send, chal);
        @(negedge clk);
        check("done_width", bus.done, 1'b0);
        check("idle_busy", bus.busy, 1'b0);
        check("start_pulses", slave_pulses - p0, exp_att);
        check("start_high_cycles", start_high - h0, 2 * exp_att);
        for (int i = r0 + 1; i < rise_q.size(); i++)
            check("retry_spacing", rise_q[i] - rise_q[i-1], RETRY_PERIOD);
        repeat (3) @(negedge clk);
        check("sticky_pass", bus.pass, exp_pass);
        check("sticky_fail", bus.fail, !exp_pass);
        check("done_count", done_count - d0, 1);
        check("never_both", both_count - b0, 0);
    endtask

    vec_t vecs[4];

    initial begin
        int t, p0, dt0, dt1, nd;
        bit   rp;
        int   ratt, rdone, nw;
        logic [31:0] rc, re;

        vecs[0] = '{32'h1234_5678, 32'hA5C3_0F1E, 0, 1'b0, 1'b1, 1, 349};
        vecs[1] = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 2, 1'b0, 1'b1, 3, 1081};
        vecs[2] = '{32'hCAFE_0001, 32'h7777_1111, 9, 1'b0, 1'b0, 3, 1081};
        vecs[3] = '{32'h0F0F_F0F0, 32'h1357_9BDF, 1, 1'b1, 1'b1, 2, 715};

        bus.auth_req = 1'b0; bus.challenge = '0; bus.expected_resp = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {bus.spi_start, bus.busy, bus.done, bus.pass, bus.fail}, 5'b0);
        check("rst_attempts", bus.attempts, 4'd0);
        check("rst_data", bus.spi_data_to_send, 32'h0);
        check("rst_response", bus.response, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_hold", {bus.spi_start, bus.busy}, 2'b00);

        for (int i = 0; i < 4; i++)
            run_exchange(vecs[i].chal, vecs[i].resp, vecs[i].n_wrong, vecs[i].disturb,
                         vecs[i].exp_pass, vecs[i].exp_att, vecs[i].exp_done);

        for (int i = 0; i < 6; i++) begin
            nw = $urandom_range(0, 4);
            rc = $urandom; re = $urandom;
            model(nw, rp, ratt, rdone);
            run_exchange(rc, re, nw, 1'($urandom_range(0, 1)), rp, ratt, rdone);
        end

        // Reset while waiting on the second attempt's transfer.
        configure_slave(32'h4444_2222, 10);
        p0 = slave_pulses;
        @(negedge clk);
        bus.auth_req = 1'b1; bus.challenge = 32'h9999_AAAA; bus.expected_resp = 32'h4444_2222;
        @(negedge clk);
        bus.auth_req = 1'b0;
        t = 0;
        while ((slave_pulses - p0) < 2 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_reached_attempt2", slave_pulses - p0, 2);
        repeat (50) @(negedge clk);
        check("rst_mid_pre_attempts", bus.attempts, 4'd2);
        check("rst_mid_pre_busy", bus.busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_start", bus.spi_start, 1'b0);
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_attempts", bus.attempts, 4'd0);
        check("rst_mid_pass_fail", {bus.pass, bus.fail}, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        run_exchange(32'h0101_0202, 32'hFEED_FACE, 0, 1'b0, 1'b1, 1, 349);

        // auth_req held high: a failing exchange followed immediately by a passing one.
        configure_slave(32'h3C3C_5A5A, 3);
        p0 = slave_pulses;
        @(negedge clk);
        bus.auth_req = 1'b1; bus.challenge = 32'h8765_4321; bus.expected_resp = 32'h3C3C_5A5A;
        @(negedge clk);
        t = 0; nd = 0; dt0 = -1; dt1 = -1;
        while (nd < 2 && t < 4000) begin
            if (bus.done === 1'b1) begin
                if (nd == 0) begin
                    dt0 = t;
                    check("hold_first_fail", {bus.pass, bus.fail}, 2'b01);
                end else begin
                    dt1 = t;
                    bus.auth_req = 1'b0;
                    check("hold_second_pass", {bus.pass, bus.fail}, 2'b10);
                    check("hold_second_attempts", bus.attempts, 4'd1);
                end
                nd++;
            end else if (nd == 1 && t == dt0 + 1) begin
                check("hold_reaccept_start", bus.spi_start, 1'b1);
                check("hold_reaccept_cleared", {bus.pass, bus.fail}, 2'b00);
                check("hold_reaccept_attempts", bus.attempts, 4'd1);
            end
            if (nd < 2) begin
                @(negedge clk);
                t++;
            end
        end
        check("hold_first_done", dt0, XFER_WAIT + 1 + (MAX_ATTEMPTS - 1) * RETRY_PERIOD);
        check("hold_second_done", dt1, dt0 + 1 + XFER_WAIT + 1);
        @(negedge clk);
        check("hold_release_busy", bus.busy, 1'b0);
        check("hold_total_pulses", slave_pulses - p0, MAX_ATTEMPTS + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
